clken_gen: RTL and testbench



---
 rtl/clken_gen_pkg.sv | 15 +
 rtl/clken_acc.sv | 50 +++++
 rtl/clken_gen.sv | 116 +++++++++++
 tb/tb_clken_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clken_gen_pkg;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      RUN    = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Width of a select for n items, never below one bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clken_acc.sv
// One channel's phase accumulator: steps num/den per cycle and emits a registered enable.
module clken_acc #(
   parameter int               ACC_W    = 16,
   parameter logic [ACC_W-1:0] INIT_NUM = 1,
   parameter logic [ACC_W-1:0] INIT_DEN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [ACC_W-1:0] load_num,
   input  logic [ACC_W-1:0] load_den,
   output logic             cen
);

   logic [ACC_W-1:0] num, den, acc;
   logic [ACC_W:0]   sum, rem;

   always_comb begin
      sum = {1'b0, acc} + {1'b0, num};
      rem = sum - {1'b0, den};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num <= INIT_NUM;
         den <= INIT_DEN;
         acc <= '0;
         cen <= 1'b0;
      end else if (load) begin
         num <= load_num;
         den <= load_den;
         acc <= '0;
         cen <= 1'b0;
      end else if (den == '0) begin
         acc <= '0;
         cen <= 1'b0;
      end else if (num >= den) begin
         // Ratio >= 1 saturates; parking acc at 0 keeps it from creeping up and wrapping.
         acc <= '0;
         cen <= 1'b1;
      end else if (sum >= {1'b0, den}) begin
         acc <= rem[ACC_W-1:0];
         cen <= 1'b1;
      end else begin
         acc <= sum[ACC_W-1:0];
         cen <= 1'b0;
      end
   end

endmodule

// File: rtl/clken_gen.sv
// NUM_CH fractional clock-enable strobes with runtime retuning and a lock flag.
// Define CLKEN_GEN_COUNT_EN to add per-channel 32-bit cen_count outputs.
module clken_gen
   import clken_gen_pkg::*;
#(
   parameter int                      NUM_CH      = 4,
   parameter int                      ACC_W       = 16,
   parameter int                      LOCK_CYCLES = 16,
   parameter logic [NUM_CH*ACC_W-1:0] INIT_NUM    = {16'd1, 16'd2, 16'd1, 16'd1},
   parameter logic [NUM_CH*ACC_W-1:0] INIT_DEN    = {16'd3, 16'd7, 16'd2, 16'd1}
) (
   input  logic                      refclk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]          cfg_num,
   input  logic [ACC_W-1:0]          cfg_den,
   output logic [NUM_CH-1:0]         cen,
   output logic                      locked
`ifdef CLKEN_GEN_COUNT_EN
   ,
   output logic [NUM_CH*32-1:0]      cen_count
`endif
);

   localparam int CH_W  = ch_w(NUM_CH);
   localparam int CNT_W = ch_w(LOCK_CYCLES + 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              take;
   logic [CH_W-1:0]   upd_ch;
   logic [ACC_W-1:0]  upd_num, upd_den;
   logic [NUM_CH-1:0] load;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      take     = 1'b0;
      case (state)
         SETTLE: begin
            if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (cfg_valid) begin
               state_nx = UPDATE;
               take     = 1'b1;
            end
         end
         UPDATE: begin
            state_nx = SETTLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = SETTLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign cfg_ready = (state == RUN);

   always_ff @(posedge refclk) begin
      if (rst) begin
         state   <= SETTLE;
         cnt     <= '0;
         locked  <= 1'b0;
         upd_ch  <= '0;
         upd_num <= '0;
         upd_den <= '0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         locked <= (state_nx == RUN);
         if (take) begin
            upd_ch  <= cfg_ch;
            upd_num <= cfg_num;
            upd_den <= cfg_den;
         end
      end
   end

   // Out-of-range channel numbers match no lane, so the update is a no-op apart from re-settling.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = (state == UPDATE) && (upd_ch == CH_W'(i));

      clken_acc #(
         .ACC_W    (ACC_W),
         .INIT_NUM (INIT_NUM[i*ACC_W +: ACC_W]),
         .INIT_DEN (INIT_DEN[i*ACC_W +: ACC_W])
      ) u_acc (
         .clk      (refclk),
         .rst      (rst),
         .load     (load[i]),
         .load_num (upd_num),
         .load_den (upd_den),
         .cen      (cen[i])
      );

`ifdef CLKEN_GEN_COUNT_EN
      logic [31:0] count;
      always_ff @(posedge refclk) begin
         if (rst || load[i]) count <= '0;
         else                count <= count + 32'(cen[i]);
      end
      assign cen_count[i*32 +: 32] = count;
`endif
   end

endmodule

// File: tb/tb_clken_gen.sv
// Directed scoreboard bench for clken_gen: lock timing, enable rates, retuning and reset.
module tb_clken_gen;

   logic        refclk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [15:0] cfg_num = '0, cfg_den = '0;
   logic        cfg_ready, locked;
   logic [3:0]  cen;

   // Three-channel instance so an out-of-range channel number fits the 2-bit port.
   logic        x_valid = 1'b0;
   logic [1:0]  x_ch = '0;
   logic [15:0] x_num = '0, x_den = '0;
   logic        x_ready, x_locked;
   logic [2:0]  x_cen;

`ifdef CLKEN_GEN_COUNT_EN
   logic [127:0] cen_count;
   logic [95:0]  x_cen_count;
`endif

   int vectors = 0, miscompares = 0;
   int exp_q[$];
   int ones[4];
   int lock_at;
   logic [3:0] cen_upd;
   logic rdy_after, lk_after;
   int tot0 = 0;

   always #5 refclk = ~refclk;

   clken_gen u_dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den), .cen(cen), .locked(locked)
`ifdef CLKEN_GEN_COUNT_EN
      , .cen_count(cen_count)
`endif
   );

   clken_gen #(
      .NUM_CH(3), .ACC_W(16), .LOCK_CYCLES(16),
      .INIT_NUM(48'h0002_0001_0001), .INIT_DEN(48'h0007_0002_0001)
   ) u_dut3 (
      .refclk(refclk), .rst(rst), .cfg_valid(x_valid), .cfg_ready(x_ready),
      .cfg_ch(x_ch), .cfg_num(x_num), .cfg_den(x_den), .cen(x_cen), .locked(x_locked)
`ifdef CLKEN_GEN_COUNT_EN
      , .cen_count(x_cen_count)
`endif
   );

   task automatic tick();
      logic r, c;
      r = rst;
      c = cen[0];
      @(posedge refclk);
      #1;
      tot0 = r ? 0 : tot0 + int'(c);
   endtask

   task automatic expect_val(input int v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input int obs);
      int e;
      e = exp_q.pop_front();
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
   endtask

   // Count each channel's enables over n cycles.
   task automatic count_win(input int n);
      foreach (ones[c]) ones[c] = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         for (int c = 0; c < 4; c++) ones[c] += int'(cen[c]);
      end
   endtask

   // Retune one channel; ones[] covers the win cycles after the load, lock_at counts from the transfer.
   task automatic reconfig(input logic [1:0] ch, input logic [15:0] num, input logic [15:0] den,
                           input int win);
      int guard;
      guard = 0;
      cfg_ch = ch; cfg_num = num; cfg_den = den; cfg_valid = 1'b1;
      while (!cfg_ready && guard < 200) begin
         tick();
         guard++;
      end
      expect_val(1); check("cfg_ready_wait", int'(cfg_ready));
      tick();
      cfg_valid = 1'b0;
      rdy_after = cfg_ready;
      lk_after  = locked;
      lock_at   = -1;
      foreach (ones[c]) ones[c] = 0;
      for (int i = 1; (i <= win + 1) || (lock_at < 0 && i <= 200); i++) begin
         tick();
         if (i == 1) cen_upd = cen;
         else if (i <= win + 1)
            for (int c = 0; c < 4; c++) ones[c] += int'(cen[c]);
         if (lock_at < 0 && locked) lock_at = i;
      end
   endtask

   initial begin
      int n;
      // Reset state
      tick(); tick();
      expect_val(0); check("reset_cen", int'(cen));
      expect_val(0); check("reset_locked", int'(locked));
      expect_val(0); check("reset_cfg_ready", int'(cfg_ready));
      rst = 1'b0;
      n = 0;
      while (!locked && n < 100) begin tick(); n++; end
      expect_val(16); check("lock_after_reset", n);
      expect_val(1);  check("ready_when_locked", int'(cfg_ready));

      // Default ratios over 84 cycles
      count_win(84);
      expect_val(84); check("rate_ch0", ones[0]);
      expect_val(42); check("rate_ch1", ones[1]);
      expect_val(24); check("rate_ch2", ones[2]);
      expect_val(28); check("rate_ch3", ones[3]);

      // ch3 -> 3/8
      reconfig(2'd3, 16'd3, 16'd8, 80);
      expect_val(0);  check("ready_drop", int'(rdy_after));
      expect_val(0);  check("locked_drop", int'(lk_after));
      expect_val(0);  check("ch3_cen_on_update", int'(cen_upd[3]));
      expect_val(1);  check("ch0_cen_on_update", int'(cen_upd[0]));
      expect_val(30); check("ch3_3of8_80", ones[3]);
      expect_val(80); check("ch0_undisturbed", ones[0]);
      expect_val(40); check("ch1_undisturbed", ones[1]);
      expect_val(17); check("relock_ch3", lock_at);

      // ch1 disabled
      reconfig(2'd1, 16'd1, 16'd0, 40);
      expect_val(0);  check("ch1_den0_upd", int'(cen_upd[1]));
      expect_val(0);  check("ch1_den0_rate", ones[1]);
      expect_val(17); check("relock_ch1", lock_at);

      // Ratios at and above one
      reconfig(2'd2, 16'd5, 16'd5, 20);
      expect_val(20); check("ch2_5of5", ones[2]);
      reconfig(2'd2, 16'd9, 16'd5, 20);
      expect_val(20); check("ch2_9of5", ones[2]);

      // Reset during SETTLE after an update
      cfg_ch = 2'd3; cfg_num = 16'd3; cfg_den = 16'd8; cfg_valid = 1'b1;
      n = 0;
      while (!cfg_ready && n < 200) begin tick(); n++; end
      tick();
      cfg_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      expect_val(0); check("rst_mid_cen", int'(cen));
      expect_val(0); check("rst_mid_locked", int'(locked));
      expect_val(0); check("rst_mid_ready", int'(cfg_ready));
      rst = 1'b0;
      n = 0;
      while (!cfg_ready && n < 100) begin tick(); n++; end
      expect_val(16); check("ready_after_rst", n);
      count_win(84);
      expect_val(84); check("post_rst_ch0", ones[0]);
      expect_val(42); check("post_rst_ch1", ones[1]);
      expect_val(24); check("post_rst_ch2", ones[2]);
      expect_val(28); check("post_rst_ch3", ones[3]);

      // Out-of-range channel on the three-channel instance
      x_ch = 2'd3; x_num = 16'd0; x_den = 16'd0; x_valid = 1'b1;
      expect_val(1); check("x_ready_before", int'(x_ready));
      tick();
      x_valid = 1'b0;
      expect_val(0); check("x_ready_drop", int'(x_ready));
      expect_val(0); check("x_locked_drop", int'(x_locked));
      foreach (ones[c]) ones[c] = 0;
      lock_at = -1;
      for (int i = 1; i <= 85; i++) begin
         tick();
         if (i >= 2) for (int c = 0; c < 3; c++) ones[c] += int'(x_cen[c]);
         if (lock_at < 0 && x_locked) lock_at = i;
      end
      expect_val(84); check("x_ch0_rate", ones[0]);
      expect_val(42); check("x_ch1_rate", ones[1]);
      expect_val(24); check("x_ch2_rate", ones[2]);
      expect_val(17); check("x_relock", lock_at);

`ifdef CLKEN_GEN_COUNT_EN
      expect_val(tot0); check("cen_count_ch0", int'(cen_count[31:0]));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
